vram_write_arbiter: RTL and testbench
=====================================

Name: vram_write_arbiter

Overview:
- Shares the single framebuffer write port between all N_CORES compute cores.
- Each core issues byte-wide VRAM writes, addressed as 320x240 8-bit pixels.
- The block grants one core per cycle using round-robin priority, converts the pixel address to a 64-bit framebuffer word address plus a byte-enable, and holds the write in a registered output stage with backpressure.
- It sits between the core array and the framebuffer memory, alongside the scanout read port.

Parameters:
- N_REQ, default attrs::N_CORES (12), number of requesting cores.
- CNT_WIDTH, default 16, width of the saturating dropped-write counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-core write request.
- req_addr  in  N_REQ x vram_addr_t  pixel address per core.
- req_data  in  N_REQ x vram_word_t  pixel data per core.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- fb_we  out  1  write valid to the framebuffer.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- fb_addr  out  fb_addr_t  word address.
- fb_wdata  out  fb_word_t  pixel byte replicated into all 8 lanes.
- fb_be  out  FB_BYTES  byte enable, one-hot.
- drop_count  out  CNT_WIDTH  count of out-of-range writes, saturating.

Behaviour:
- Reset (synchronous, active-high): fb_we=0, fb_addr=0, fb_wdata=0, fb_be=0, drop_count=0, priority pointer=0. req_ready is all zero while rst=1.
- Any write held in the output stage when reset asserts is discarded, not completed.
- can_accept = !fb_we || fb_ready. The output stage is empty, or it drains this cycle.
- Arbitration (combinational, same cycle):
  - Only when can_accept is high.
  - Scan indices ptr, ptr+1, ..., wrapping at N_REQ-1 to 0.
  - The first index with req_valid set gets req_ready=1.
  - No grant when can_accept=0. req_ready is never asserted without req_valid.
- On a grant to core g:
  - ptr <= (g==N_REQ-1) ? 0 : g+1.
  - ptr is unchanged on cycles with no grant.
- Address conversion for an in-range grant (req_addr < VRAM_DEPTH = 76800):
  - fb_addr <= req_addr >> 3.
  - lane = req_addr[2:0].
  - fb_be <= 1 << lane.
  - fb_wdata <= {8{req_data}}.
  - fb_we <= 1.
  - Latency is 1 cycle from handshake to fb_we.
- Out-of-range grant (req_addr >= 76800):
  - Handshake still completes, so the core is not stalled.
  - The output stage is not loaded: fb_we becomes 0 if it was draining, otherwise it holds.
  - drop_count increments, saturating at all-ones.
- Output stage behaviour:
  - When fb_we=1 and fb_ready=0, fb_addr, fb_wdata and fb_be hold stable.
  - When fb_ready=1 with no new in-range grant, fb_we <= 0.
  - Throughput: one write per cycle while fb_ready stays high.
- Fairness: a continuously requesting core waits at most N_REQ-1 grants.
- No coalescing: two writes to the same word are issued as separate transfers, in grant order.

Decomposition:
- Add to package attrs:
  - FB_BYTES = FB_WIDTH/VRAM_WIDTH (8).
  - FB_LANE_WIDTH = $clog2(FB_BYTES).
  - typedef fb_be_t = logic[FB_BYTES-1:0].
- Add to package attrs: a packed struct vram_wr_t {vram_addr_t addr; vram_word_t data;}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N], en, ptr.
  - Outputs grant one-hot and grant_idx (core_id_t).
  - Purely combinational. The pointer register stays in vram_write_arbiter.

Test Plan:
- Reset then single request: core 3 writes addr 10, data 0xA5, with fb_ready=1 → req_ready=0x008. Next cycle fb_we=1, fb_addr=1, fb_be=0x04, fb_wdata=0xA5A5A5A5A5A5A5A5.
- All 12 cores request continuously with fb_ready=1 → grants go to cores 0,1,...,11,0 over 13 cycles. Exactly one grant per cycle, ptr wraps from 11 to 0.
- Backpressure: fb_ready=0 for 3 cycles while fb_we=1 and cores 5 and 7 are requesting → req_ready=0 throughout and the fb outputs stay stable. When fb_ready rises, core 5 is granted first, then core 7.
- Out-of-range write: core 0 writes addr 76800 → handshake completes, fb_we stays 0, drop_count=1. Repeat 65536 times → drop_count saturates at 0xFFFF.
- Reset mid-operation: assert rst while fb_we=1 and fb_ready=0 → next cycle fb_we=0, ptr=0, and no write completes. The first request after reset from core 0 is granted.
- Boundary address 76799, data 0x3C → fb_addr=9599, fb_be=0x80.

Source files
------------

// File: rtl/vram_write_arbiter_pkg.sv
// Shared framebuffer attributes: VRAM geometry, framebuffer word layout and
// the small address helpers used by the write arbiter.
package attrs;

    localparam int N_CORES       = 12;
    localparam int VRAM_COLS     = 320;
    localparam int VRAM_ROWS     = 240;
    localparam int VRAM_DEPTH    = VRAM_COLS * VRAM_ROWS;
    localparam int VRAM_WIDTH    = 8;
    localparam int FB_WIDTH      = 64;

    localparam int VRAM_ADDR_WIDTH = $clog2(VRAM_DEPTH);
    localparam int FB_BYTES        = FB_WIDTH / VRAM_WIDTH;
    localparam int FB_LANE_WIDTH   = $clog2(FB_BYTES);
    localparam int FB_ADDR_WIDTH   = VRAM_ADDR_WIDTH - FB_LANE_WIDTH;
    localparam int CORE_ID_WIDTH   = $clog2(N_CORES);

    typedef logic [VRAM_ADDR_WIDTH-1:0] vram_addr_t;
    typedef logic [VRAM_WIDTH-1:0]      vram_word_t;
    typedef logic [FB_ADDR_WIDTH-1:0]   fb_addr_t;
    typedef logic [FB_WIDTH-1:0]        fb_word_t;
    typedef logic [FB_BYTES-1:0]        fb_be_t;
    typedef logic [CORE_ID_WIDTH-1:0]   core_id_t;

    typedef struct packed {
        vram_addr_t addr;
        vram_word_t data;
    } vram_wr_t;

    function automatic logic pixel_in_range(input vram_addr_t addr);
        return addr < vram_addr_t'(VRAM_DEPTH);
    endfunction

    function automatic fb_addr_t word_addr(input vram_addr_t addr);
        return fb_addr_t'(addr >> FB_LANE_WIDTH);
    endfunction

    function automatic fb_be_t lane_be(input vram_addr_t addr);
        return fb_be_t'(1) << addr[FB_LANE_WIDTH-1:0];
    endfunction

    function automatic fb_word_t replicate_pixel(input vram_word_t data);
        return {FB_BYTES{data}};
    endfunction

endpackage

// File: rtl/vram_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward with wrap and
// grants the first active request. The pointer register lives in the parent.
module rr_arbiter
    import attrs::*;
#(
    parameter int N = N_CORES
) (
    input  logic [N-1:0] req,
    input  logic         en,
    input  core_id_t     ptr,
    output logic [N-1:0] grant,
    output core_id_t     grant_idx
);

    localparam int IDX_W = $bits(core_id_t);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] scan_idx;
    logic             found;

    // The scan index is kept one bit wider than ptr so the wrap test cannot overflow.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = {1'b0, ptr} + SUM_W'(i);
            if (scan_idx >= SUM_W'(N)) begin
                scan_idx = scan_idx - SUM_W'(N);
            end
            if (en && !found && req[scan_idx[IDX_W-1:0]]) begin
                grant[scan_idx[IDX_W-1:0]] = 1'b1;
                grant_idx                  = scan_idx[IDX_W-1:0];
                found                      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the framebuffer write port among the compute cores: round-robin grant,
// pixel-to-word address conversion, and a registered output stage with backpressure.
module vram_write_arbiter
    import attrs::*;
#(
    parameter int N_REQ     = N_CORES,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  vram_addr_t           req_addr [N_REQ],
    input  vram_word_t           req_data [N_REQ],
    output logic [N_REQ-1:0]     req_ready,
    output logic                 fb_we,
    input  logic                 fb_ready,
    output fb_addr_t             fb_addr,
    output fb_word_t             fb_wdata,
    output fb_be_t               fb_be,
    output logic [CNT_WIDTH-1:0] drop_count
);

    core_id_t             ptr_q,        ptr_d;
    logic                 fb_we_q,      fb_we_d;
    fb_addr_t             fb_addr_q,    fb_addr_d;
    fb_word_t             fb_wdata_q,   fb_wdata_d;
    fb_be_t               fb_be_q,      fb_be_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic       can_accept;
    logic       arb_en;
    logic       granted;
    core_id_t   grant_idx;
    vram_wr_t   sel_wr;
    logic [N_REQ-1:0] grant;

    // Grants are suppressed during reset so no core sees a handshake that is then lost.
    assign can_accept = !fb_we_q || fb_ready;
    assign arb_en     = can_accept && !rst;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .en        (arb_en),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign granted   = |grant;
    assign req_ready = grant;

    always_comb begin
        sel_wr.addr = req_addr[grant_idx];
        sel_wr.data = req_data[grant_idx];
    end

    // Out-of-range grants still complete the handshake but only bump the drop counter.
    always_comb begin
        ptr_d        = ptr_q;
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        fb_be_d      = fb_be_q;
        drop_count_d = drop_count_q;

        if (fb_we_q && fb_ready) begin
            fb_we_d = 1'b0;
        end

        if (granted) begin
            ptr_d = (grant_idx == core_id_t'(N_REQ - 1)) ? '0 : grant_idx + core_id_t'(1);
            if (pixel_in_range(sel_wr.addr)) begin
                fb_we_d    = 1'b1;
                fb_addr_d  = word_addr(sel_wr.addr);
                fb_be_d    = lane_be(sel_wr.addr);
                fb_wdata_d = replicate_pixel(sel_wr.data);
            end else if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            fb_be_q      <= '0;
            drop_count_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            fb_be_q      <= fb_be_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign fb_be      = fb_be_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: reset, single write, round-robin order,
// backpressure, dropped writes with saturation, mid-operation reset and address boundary.
module tb_vram_write_arbiter;
    import attrs::*;

    logic              clk;
    logic              rst;
    logic [N_CORES-1:0] req_valid;
    vram_addr_t        req_addr [N_CORES];
    vram_word_t        req_data [N_CORES];
    logic [N_CORES-1:0] req_ready;
    logic              fb_we;
    logic              fb_ready;
    fb_addr_t          fb_addr;
    fb_word_t          fb_wdata;
    fb_be_t            fb_be;
    logic [15:0]       drop_count;

    int check_count;
    int pass_count;

    vram_write_arbiter #(
        .N_REQ     (N_CORES),
        .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_be      (fb_be),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_reqs();
        req_valid = '0;
        for (int i = 0; i < N_CORES; i++) begin
            req_addr[i] = '0;
            req_data[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        fb_ready = 1'b1;
        clear_reqs();
        req_valid = 12'hFFF;
        tick();
        tick();
        #1;
        check_count++;
        if (req_ready !== 12'h000) $display("[TB] FAIL reset_req_ready got %h want 000", req_ready);
        else pass_count++;
        check_count++;
        if (fb_we !== 1'b0) $display("[TB] FAIL reset_fb_we got %b want 0", fb_we);
        else pass_count++;
        check_count++;
        if (fb_addr !== 14'd0 || fb_be !== 8'h00 || fb_wdata !== 64'd0)
            $display("[TB] FAIL reset_fb_out got addr=%0d be=%h data=%h want 0/00/0", fb_addr, fb_be, fb_wdata);
        else pass_count++;
        check_count++;
        if (drop_count !== 16'd0) $display("[TB] FAIL reset_drop_count got %0d want 0", drop_count);
        else pass_count++;
        clear_reqs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        req_valid[3] = 1'b1;
        req_addr[3]  = 17'd10;
        req_data[3]  = 8'hA5;
        #1;
        check_count++;
        if (req_ready !== 12'h008) $display("[TB] FAIL single_grant got %h want 008", req_ready);
        else pass_count++;
        tick();
        clear_reqs();
        check_count++;
        if (fb_we !== 1'b1 || fb_addr !== 14'd1 || fb_be !== 8'h04)
            $display("[TB] FAIL single_out got we=%b addr=%0d be=%h want 1/1/04", fb_we, fb_addr, fb_be);
        else pass_count++;
        check_count++;
        if (fb_wdata !== 64'hA5A5A5A5A5A5A5A5)
            $display("[TB] FAIL single_wdata got %h want a5a5a5a5a5a5a5a5", fb_wdata);
        else pass_count++;
        tick();
        check_count++;
        if (fb_we !== 1'b0) $display("[TB] FAIL single_drain got we=%b want 0", fb_we);
        else pass_count++;
    endtask

    task automatic test_round_robin();
        logic [N_CORES-1:0] exp_grant;
        int core;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fb_ready = 1'b1;
        for (int i = 0; i < N_CORES; i++) begin
            req_valid[i] = 1'b1;
            req_addr[i]  = vram_addr_t'(i * 8 + (i % 8));
            req_data[i]  = vram_word_t'(8'h10 + i);
        end
        for (int n = 0; n < 13; n++) begin
            core      = n % N_CORES;
            exp_grant = 12'b1 << core;
            #1;
            check_count++;
            if (req_ready !== exp_grant)
                $display("[TB] FAIL rr_grant[%0d] got %h want %h", n, req_ready, exp_grant);
            else pass_count++;
            tick();
            check_count++;
            if (fb_we !== 1'b1 || fb_addr !== fb_addr_t'(core) || fb_be !== (8'h01 << (core % 8))
                || fb_wdata !== {8{8'(8'h10 + core)}})
                $display("[TB] FAIL rr_out[%0d] got we=%b addr=%0d be=%h data=%h want core %0d",
                         n, fb_we, fb_addr, fb_be, fb_wdata, core);
            else pass_count++;
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fb_ready     = 1'b1;
        req_valid[2] = 1'b1;
        req_addr[2]  = 17'd100;
        req_data[2]  = 8'h11;
        tick();
        clear_reqs();
        fb_ready     = 1'b0;
        req_valid[5] = 1'b1;
        req_addr[5]  = 17'd200;
        req_data[5]  = 8'h55;
        req_valid[7] = 1'b1;
        req_addr[7]  = 17'd303;
        req_data[7]  = 8'h77;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_count++;
            if (req_ready !== 12'h000) $display("[TB] FAIL bp_no_grant[%0d] got %h want 000", c, req_ready);
            else pass_count++;
            check_count++;
            if (fb_we !== 1'b1 || fb_addr !== 14'd12 || fb_be !== 8'h10 || fb_wdata !== {8{8'h11}})
                $display("[TB] FAIL bp_hold[%0d] got we=%b addr=%0d be=%h data=%h want 1/12/10/1111..",
                         c, fb_we, fb_addr, fb_be, fb_wdata);
            else pass_count++;
            tick();
        end
        fb_ready = 1'b1;
        #1;
        check_count++;
        if (req_ready !== 12'h020) $display("[TB] FAIL bp_first_grant got %h want 020", req_ready);
        else pass_count++;
        tick();
        req_valid[5] = 1'b0;
        check_count++;
        if (fb_we !== 1'b1 || fb_addr !== 14'd25 || fb_be !== 8'h01 || fb_wdata !== {8{8'h55}})
            $display("[TB] FAIL bp_core5_out got we=%b addr=%0d be=%h data=%h want 1/25/01/5555..",
                     fb_we, fb_addr, fb_be, fb_wdata);
        else pass_count++;
        #1;
        check_count++;
        if (req_ready !== 12'h080) $display("[TB] FAIL bp_second_grant got %h want 080", req_ready);
        else pass_count++;
        tick();
        clear_reqs();
        check_count++;
        if (fb_we !== 1'b1 || fb_addr !== 14'd37 || fb_be !== 8'h80 || fb_wdata !== {8{8'h77}})
            $display("[TB] FAIL bp_core7_out got we=%b addr=%0d be=%h data=%h want 1/37/80/7777..",
                     fb_we, fb_addr, fb_be, fb_wdata);
        else pass_count++;
        tick();
    endtask

    task automatic test_out_of_range();
        fb_ready     = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 17'd76800;
        req_data[0]  = 8'hEE;
        #1;
        check_count++;
        if (req_ready !== 12'h001) $display("[TB] FAIL oor_handshake got %h want 001", req_ready);
        else pass_count++;
        tick();
        check_count++;
        if (fb_we !== 1'b0 || drop_count !== 16'd1)
            $display("[TB] FAIL oor_first got we=%b drops=%0d want 0/1", fb_we, drop_count);
        else pass_count++;
        repeat (65533) @(posedge clk);
        #1;
        check_count++;
        if (drop_count !== 16'hFFFE) $display("[TB] FAIL oor_near_sat got %h want fffe", drop_count);
        else pass_count++;
        tick();
        check_count++;
        if (drop_count !== 16'hFFFF) $display("[TB] FAIL oor_sat got %h want ffff", drop_count);
        else pass_count++;
        tick();
        tick();
        check_count++;
        if (drop_count !== 16'hFFFF || fb_we !== 1'b0)
            $display("[TB] FAIL oor_hold got drops=%h we=%b want ffff/0", drop_count, fb_we);
        else pass_count++;
        clear_reqs();
        tick();
    endtask

    task automatic test_boundary();
        fb_ready     = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 17'd76799;
        req_data[0]  = 8'h3C;
        tick();
        clear_reqs();
        check_count++;
        if (fb_we !== 1'b1 || fb_addr !== 14'd9599 || fb_be !== 8'h80 || fb_wdata !== {8{8'h3C}})
            $display("[TB] FAIL boundary_out got we=%b addr=%0d be=%h data=%h want 1/9599/80/3c3c..",
                     fb_we, fb_addr, fb_be, fb_wdata);
        else pass_count++;
        check_count++;
        if (drop_count !== 16'hFFFF) $display("[TB] FAIL boundary_no_drop got %h want ffff", drop_count);
        else pass_count++;
    endtask

    task automatic test_reset_mid();
        fb_ready     = 1'b0;
        rst          = 1'b1;
        req_valid[4] = 1'b1;
        req_addr[4]  = 17'd40;
        req_data[4]  = 8'h44;
        #1;
        check_count++;
        if (req_ready !== 12'h000) $display("[TB] FAIL midrst_no_grant got %h want 000", req_ready);
        else pass_count++;
        tick();
        check_count++;
        if (fb_we !== 1'b0 || fb_addr !== 14'd0 || drop_count !== 16'd0)
            $display("[TB] FAIL midrst_clear got we=%b addr=%0d drops=%0d want 0/0/0", fb_we, fb_addr, drop_count);
        else pass_count++;
        rst          = 1'b0;
        fb_ready     = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 17'd9;
        req_data[0]  = 8'h01;
        #1;
        check_count++;
        if (req_ready !== 12'h001) $display("[TB] FAIL midrst_ptr_zero got %h want 001", req_ready);
        else pass_count++;
        tick();
        clear_reqs();
        check_count++;
        if (fb_we !== 1'b1 || fb_addr !== 14'd1 || fb_be !== 8'h02)
            $display("[TB] FAIL midrst_first_out got we=%b addr=%0d be=%h want 1/1/02", fb_we, fb_addr, fb_be);
        else pass_count++;
        tick();
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst         = 1'b1;
        fb_ready    = 1'b1;
        clear_reqs();
        tick();
        test_reset();
        test_single_write();
        test_round_robin();
        test_backpressure();
        test_out_of_range();
        test_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
